// File: rtl/mmm_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation controller.
// Holds the operand-select codes for the external A/B mux, the controller
// state encoding and the multiplier run length, so the operand mux and the
// bench decode exactly what the controller drives.
package mmm_exp_ctrl_pkg;

  // Operand-select codes: which operands the A/B mux presents to the multiplier.
  typedef enum logic [1:0] {
    OP_SQR      = 2'd0,  // A=R,    B=R
    OP_MUL      = 2'd1,  // A=R,    B=base
    OP_CONV_IN  = 2'd2,  // A=base, B=R^2 mod M
    OP_CONV_OUT = 2'd3   // A=R,    B=1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_CLR   = 3'd2,
    ST_LOAD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_STORE = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Number of RUN cycles the Montgomery multiplier needs for a w-bit operand.
  function automatic int unsigned run_len(input int unsigned w);
    return w + 2;
  endfunction

endpackage

// File: rtl/mmm_exp_ctrl_if.sv
// Handshake and strobe bundle between a requester, the exponentiation
// controller and the Montgomery multiplier it sequences.
//   master : requester side  -> drives en, start, E; observes status/strobes
//   slave  : controller side -> receives en, start, E; drives
//            mmm_en, rst_mmm, ld_a, ld_r, lock, op, busy, done, exp_zero
interface mmm_exp_ctrl_if #(
  parameter int WIDTH = 4
);
  import mmm_exp_ctrl_pkg::*;

  logic             en;
  logic             start;
  logic [WIDTH-1:0] E;
  logic             mmm_en;
  logic             rst_mmm;
  logic             ld_a;
  logic             ld_r;
  logic             lock;
  op_e              op;
  logic             busy;
  logic             done;
  logic             exp_zero;

  modport master (
    output en, start, E,
    input  mmm_en, rst_mmm, ld_a, ld_r, lock, op, busy, done, exp_zero
  );

  modport slave (
    input  en, start, E,
    output mmm_en, rst_mmm, ld_a, ld_r, lock, op, busy, done, exp_zero
  );

endinterface

// File: rtl/mmm_exp_ctrl_iter_counter.sv
// mmm_iter_counter: down-counter timing the multiplier RUN phase.
// Ports:
//   clk, rstb  clock, asynchronous active-low reset (count clears to 0)
//   en         global enable; count holds while low
//   load       load load_val (takes priority over dec)
//   dec        decrement by one, saturating at zero
//   load_val   value loaded on load
//   zero       high when the count is zero
module mmm_iter_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] itcnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      itcnt <= '0;
    end else if (en) begin
      if (load) begin
        itcnt <= load_val;
      end else if (dec && (itcnt != '0)) begin
        itcnt <= itcnt - CNT_W'(1);
      end
    end
  end

  assign zero = (itcnt == '0);

endmodule

// File: rtl/mmm_exp_ctrl.sv
// mmm_exp_ctrl: left-to-right square-and-multiply sequencer for a Montgomery
// multiplier. Scans the exponent for its leading one, converts the base into
// the Montgomery domain, then issues SQR (and MUL for every set bit) per
// remaining exponent bit and finally converts out. Each multiplier operation
// is CLR -> LOAD -> RUN (WIDTH+2 cycles) -> STORE.
// Ports:
//   clk   clock (rising edge)
//   rstb  asynchronous active-low reset
//   bus   mmm_exp_ctrl_if.slave: en/start/E in; mmm_en, rst_mmm, ld_a, ld_r,
//         lock, op, busy, done, exp_zero out
module mmm_exp_ctrl
  import mmm_exp_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rstb,
  mmm_exp_ctrl_if.slave bus
);

  localparam int BC_W = $clog2(WIDTH + 1);
  localparam int IC_W = $clog2(WIDTH + 3);
  localparam logic [BC_W-1:0] BC_INIT = BC_W'(WIDTH);
  // Counter runs load value down to zero inclusive, so load one less.
  localparam logic [IC_W-1:0] IC_LOAD = IC_W'(run_len(WIDTH) - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ebits_q, ebits_d;
  logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
  op_e              op_q, op_d;
  // Exponent bit most recently shifted out; decides whether a SQR is
  // followed by a MUL.
  logic             cur_bit_q, cur_bit_d;
  logic             exp_zero_q, exp_zero_d;
  logic             it_load, it_dec, it_zero;

  mmm_iter_counter #(
    .CNT_W (IC_W)
  ) u_iter (
    .clk      (clk),
    .rstb     (rstb),
    .en       (bus.en),
    .load     (it_load),
    .dec      (it_dec),
    .load_val (IC_LOAD),
    .zero     (it_zero)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      ebits_q    <= '0;
      bitcnt_q   <= '0;
      op_q       <= OP_SQR;
      cur_bit_q  <= 1'b0;
      exp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ebits_q    <= ebits_d;
      bitcnt_q   <= bitcnt_d;
      op_q       <= op_d;
      cur_bit_q  <= cur_bit_d;
      exp_zero_q <= exp_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ebits_d    = ebits_q;
    bitcnt_d   = bitcnt_q;
    op_d       = op_q;
    cur_bit_d  = cur_bit_q;
    exp_zero_d = exp_zero_q;
    it_load    = 1'b0;
    it_dec     = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            ebits_d    = bus.E;
            bitcnt_d   = BC_INIT;
            exp_zero_d = 1'b0;
            state_d    = ST_SCAN;
          end
        end
        ST_SCAN: begin
          ebits_d   = ebits_q << 1;
          bitcnt_d  = bitcnt_q - BC_W'(1);
          cur_bit_d = ebits_q[WIDTH-1];
          if (ebits_q[WIDTH-1]) begin
            op_d    = OP_CONV_IN;
            state_d = ST_CLR;
          end else if (bitcnt_q == BC_W'(1)) begin
            exp_zero_d = 1'b1;
            state_d    = ST_DONE;
          end
        end
        ST_CLR: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          it_load = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (it_zero) begin
            state_d = ST_STORE;
          end else begin
            it_dec = 1'b1;
          end
        end
        ST_STORE: begin
          state_d = ST_CLR;
          if (op_q == OP_CONV_OUT) begin
            state_d = ST_DONE;
          end else if ((op_q == OP_SQR) && cur_bit_q) begin
            op_d = OP_MUL;
          end else if (bitcnt_q == '0) begin
            op_d = OP_CONV_OUT;
          end else begin
            ebits_d   = ebits_q << 1;
            bitcnt_d  = bitcnt_q - BC_W'(1);
            cur_bit_d = ebits_q[WIDTH-1];
            op_d      = OP_SQR;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Strobes decode directly from the state register, so they freeze with it
  // when en is low and take their reset values as soon as rstb falls.
  assign bus.mmm_en   = bus.en;
  assign bus.rst_mmm  = (state_q != ST_CLR);
  assign bus.ld_a     = (state_q == ST_LOAD);
  assign bus.ld_r     = (state_q == ST_STORE);
  assign bus.lock     = (state_q != ST_STORE);
  assign bus.op       = op_q;
  assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.exp_zero = exp_zero_q;

endmodule

// File: tb/tb_mmm_exp_ctrl.sv
// Directed bench for mmm_exp_ctrl (WIDTH=4). Each run starts with start
// sampled in cycle 0; the monitor numbers cycles from there and records
// strobes, the op sequence at each LOAD and the cycle in which done shows.
module tb_mmm_exp_ctrl;
  import mmm_exp_ctrl_pkg::*;

  logic clk;
  logic rstb;
  int   checks;
  int   failures;

  mmm_exp_ctrl_if #(.WIDTH(4)) bus ();

  mmm_exp_ctrl #(.WIDTH(4)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results of the last run_exp
  int          cyc;
  int          done_cyc;
  int          done_w;
  int          n_lda;
  int          n_ldr;
  int          n_busy;
  int          unstable;
  logic        zero_at_done;
  logic [31:0] seq;

  task automatic run_exp(input logic [3:0] e, input bit hold, input int gate_at,
                         input int gate_len, input int chg_at, input logic [3:0] chg_e);
    logic [1:0] op_at_clr;
    seq = 0; n_lda = 0; n_ldr = 0; n_busy = 0; unstable = 0;
    done_cyc = -1; done_w = 0; zero_at_done = 1'b0; op_at_clr = 2'd0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.E     = e;
    @(posedge clk);
    cyc = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (cyc == chg_at) bus.E = chg_e;
      bus.en = (gate_len > 0) ? !((cyc >= gate_at) && (cyc < gate_at + gate_len)) : 1'b1;
      if (bus.done) begin
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          zero_at_done = bus.exp_zero;
        end
        done_w++;
      end else if (done_cyc >= 0) begin
        break;
      end
      if (bus.busy) n_busy++;
      if (!bus.rst_mmm) op_at_clr = bus.op;
      if (bus.en && bus.ld_a) begin
        n_lda++;
        seq = (seq << 2) | 32'(bus.op);
      end
      if (bus.en && bus.ld_r) begin
        n_ldr++;
        if (bus.op != op_at_clr) unstable++;
      end
      @(posedge clk);
      cyc++;
    end
    bus.en = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rstb = 1'b0; bus.en = 1'b1; bus.start = 1'b0; bus.E = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_exp_zero", 32'(bus.exp_zero), 32'd0);
    chk("rst_ld_a",     32'(bus.ld_a),     32'd0);
    chk("rst_ld_r",     32'(bus.ld_r),     32'd0);
    chk("rst_rst_mmm",  32'(bus.rst_mmm),  32'd1);
    chk("rst_lock",     32'(bus.lock),     32'd1);
    chk("rst_op",       32'(bus.op),       32'd0);
    @(negedge clk);
    rstb = 1'b1;

    // E=0: four SCAN cycles, done with exp_zero in cycle 5, no loads
    run_exp(4'b0000, 1'b0, 0, 0, -1, 4'd0);
    chk("e0_done_cyc",  32'(done_cyc),     32'd5);
    chk("e0_zero",      32'(zero_at_done), 32'd1);
    chk("e0_lda",       32'(n_lda),        32'd0);
    chk("e0_busy",      32'(n_busy),       32'd4);
    chk("e0_done_w",    32'(done_w),       32'd1);
    chk("e0_zero_hold", 32'(bus.exp_zero), 32'd1);

    // E=1: CONV_IN, CONV_OUT
    run_exp(4'b0001, 1'b0, 0, 0, -1, 4'd0);
    chk("e1_done_cyc", 32'(done_cyc),     32'd23);
    chk("e1_seq",      seq,               32'hB);
    chk("e1_lda",      32'(n_lda),        32'd2);
    chk("e1_ldr",      32'(n_ldr),        32'd2);
    chk("e1_zero",     32'(zero_at_done), 32'd0);
    chk("e1_op_stab",  32'(unstable),     32'd0);

    // E=1011: CONV_IN,SQR,SQR,MUL,SQR,MUL,CONV_OUT
    run_exp(4'b1011, 1'b0, 0, 0, -1, 4'd0);
    chk("e11_done_cyc", 32'(done_cyc), 32'd65);
    chk("e11_seq",      seq,           32'h2047);
    chk("e11_lda",      32'(n_lda),    32'd7);
    chk("e11_ldr",      32'(n_ldr),    32'd7);
    chk("e11_op_stab",  32'(unstable), 32'd0);

    // E=1011 with en low for cycles 8..12 (inside the first RUN)
    run_exp(4'b1011, 1'b0, 8, 5, -1, 4'd0);
    chk("gate_done_cyc", 32'(done_cyc), 32'd70);
    chk("gate_seq",      seq,           32'h2047);
    chk("gate_ldr",      32'(n_ldr),    32'd7);

    // en low in the DONE cycle and the next stretches done to three cycles
    run_exp(4'b0000, 1'b0, 5, 2, -1, 4'd0);
    chk("dgate_done_cyc", 32'(done_cyc), 32'd5);
    chk("dgate_done_w",   32'(done_w),   32'd3);

    // Reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1; bus.E = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    rstb = 1'b0;
    #1;
    chk("mid_busy",    32'(bus.busy),    32'd0);
    chk("mid_done",    32'(bus.done),    32'd0);
    chk("mid_ld_a",    32'(bus.ld_a),    32'd0);
    chk("mid_ld_r",    32'(bus.ld_r),    32'd0);
    chk("mid_rst_mmm", 32'(bus.rst_mmm), 32'd1);
    chk("mid_lock",    32'(bus.lock),    32'd1);
    chk("mid_op",      32'(bus.op),      32'd0);
    @(negedge clk);
    rstb = 1'b1;
    run_exp(4'b0001, 1'b0, 0, 0, -1, 4'd0);
    chk("post_rst_done_cyc", 32'(done_cyc), 32'd23);

    // start held high; E changed to 0 while busy must not affect this run
    run_exp(4'b1011, 1'b1, 0, 0, 10, 4'b0000);
    chk("hold_done_cyc", 32'(done_cyc), 32'd65);
    chk("hold_seq",      seq,           32'h2047);
    chk("hold_idle",     32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_restart", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!bus.done && waited < 50) begin
        @(posedge clk);
        @(negedge clk);
        waited++;
      end
      chk("hold2_done",     32'(bus.done),     32'd1);
      chk("hold2_exp_zero", 32'(bus.exp_zero), 32'd1);
    end
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmm_exp_ctrl.md
MMM_EXP_CTRL -- requirements
Module: mmm_exp_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, operand and exponent width in bits; SHALL match the attached Montgomery multiplier.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstb  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  global enable; when low, all state SHALL hold.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 E  input  WIDTH  exponent; captured when start is accepted.
REQ-007 mmm_en  output  1  multiplier enable; SHALL equal en combinationally.
REQ-008 rst_mmm  output  1  active-low multiplier datapath clear.
REQ-009 ld_a, ld_r, lock  output  1 each  multiplier load-operand, load-result and hold-result strobes.
REQ-010 op  output  2  operand-select code for the external A/B mux: 0 SQR (A=R, B=R), 1 MUL (A=R, B=base), 2 CONV_IN (A=base, B=R^2 mod M), 3 CONV_OUT (A=R, B=1).
REQ-011 busy  output  1  high in every state except IDLE and DONE.
REQ-012 done  output  1  one-cycle pulse at the end of an exponentiation.
REQ-013 exp_zero  output  1  qualifies done: E was zero, and the multiplier result is not valid.

Function
REQ-014 States: IDLE, SCAN, CLR, LOAD, RUN, STORE, DONE.
REQ-015 IDLE: start=1 SHALL capture E into shift register ebits, set bitcnt=WIDTH, and go to SCAN; otherwise remain in IDLE.
REQ-016 SCAN, one cycle per bit: shift ebits left and decrement bitcnt; if the shifted-out MSB=1, set op=CONV_IN and go to CLR; else if bitcnt reaches 0, go to DONE with exp_zero=1; else remain in SCAN.
REQ-017 Multiplication sequence: CLR (rst_mmm=0, 1 cycle), LOAD (ld_a=1, 1 cycle), RUN (WIDTH+2 cycles, counted by itcnt), STORE (ld_r=1, lock=0, 1 cycle); total WIDTH+5 cycles per operation.
REQ-018 After STORE, the next op SHALL be chosen as follows:
  - op was CONV_OUT -> DONE.
  - op was SQR and the current exponent bit is 1 -> MUL.
  - bitcnt=0 -> CONV_OUT.
  - otherwise -> shift ebits, decrement bitcnt, op=SQR.
  Every path except DONE SHALL return to CLR.
REQ-019 op SHALL remain stable from CLR through STORE of each operation.
REQ-020 DONE: done=1 for exactly one cycle, then go to IDLE; exp_zero SHALL hold its value until the next accepted start.
REQ-021 Outside CLR and STORE: rst_mmm=1 and lock=1. ld_a SHALL be high only in LOAD; ld_r SHALL be high only in STORE.
REQ-022 start while busy SHALL be ignored; E SHALL NOT be re-sampled.
REQ-023 en=0 in any state SHALL freeze all state, counters and outputs (except mmm_en); en=0 during DONE SHALL extend the done pulse.
REQ-024 Operation count for an exponent with leading one at position k: 1 + (k-1) + popcount(E below k) + 1.

Reset
REQ-025 rstb=0 SHALL asynchronously force the following; this applies mid-operation with no completion pulse:
  - state=IDLE; ebits, bitcnt, itcnt=0; op=0.
  - busy=0, done=0, exp_zero=0, ld_a=0, ld_r=0.
  - rst_mmm=1, lock=1.
REQ-026 The first start after reset release SHALL be accepted normally.

Structure
REQ-027 The op codes, the state enum and the run length WIDTH+2 SHALL live in the shared rsa package, for use by the operand mux and the bench.
REQ-028 The iteration counter SHALL be a separate sub-module, mmm_iter_counter (load, decrement, zero flag); everything else stays in one FSM module.

Verification (WIDTH=4, en=1, start sampled in cycle 0)
REQ-029 E=4'b0000 -> SCAN in cycles 1-4; done=1 with exp_zero=1 in cycle 5; no ld_a ever asserted.
REQ-030 E=4'b0001 -> op sequence CONV_IN, CONV_OUT; done in cycle 23; exactly 2 ld_r pulses.
REQ-031 E=4'b1011 -> op sequence CONV_IN, SQR, SQR, MUL, SQR, MUL, CONV_OUT; done in cycle 65; with the real multiplier, M=13 and base=7 SHALL yield R=7^11 mod 13=2.
REQ-032 E=4'b1011 with en=0 for 5 cycles during RUN -> done in cycle 70; strobe pattern otherwise identical.
REQ-033 rstb=0 during RUN -> all outputs at reset values immediately; a subsequent start with E=4'b0001 gives done in cycle 23.
REQ-034 start=1 held high across a full run -> exactly one run per IDLE visit; E changes while busy are ignored.
